// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the multi-channel MAC engine.
package mac_pkg;

  localparam int MAX_ACC_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  function automatic int acc_width(input int dw, input int gb);
    return (2 * dw) + gb;
  endfunction

  // Largest positive value of a w-bit two's-complement number, zero-padded.
  function automatic logic [MAX_ACC_W-1:0] sat_max(input int w);
    logic [MAX_ACC_W-1:0] r;
    r = {MAX_ACC_W{1'b0}};
    for (int i = 0; i < w - 1; i++) begin
      r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MAX_ACC_W-1:0] sat_min(input int w);
    logic [MAX_ACC_W-1:0] r;
    r = {MAX_ACC_W{1'b0}};
    r[w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/booth_seq_core.sv
// Sequential radix-2 Booth multiplier: DW steps after start, then a one-cycle done
// pulse; the product stays on the output until the next start.
module booth_seq_core #(
  parameter int DW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic signed [DW-1:0]   m,
  input  logic signed [DW-1:0]   q,
  output logic signed [2*DW-1:0] product,
  output logic                   done
);

  localparam int CNT_W = $clog2(DW + 1);

  logic [DW:0]      a_q, a_d;
  logic [DW:0]      m_q, m_d;
  logic [DW:0]      sum_s;
  logic [DW-1:0]    q_q, q_d;
  logic             q1_q, q1_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Recode {Q[0], Q[-1]}, add/subtract M into the DW+1 bit partial, then shift {A,Q,Q[-1]}.
  always_comb begin
    a_d    = a_q;
    m_d    = m_q;
    q_d    = q_q;
    q1_d   = q1_q;
    run_d  = run_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    case ({q_q[0], q1_q})
      2'b01:   sum_s = a_q + m_q;
      2'b10:   sum_s = a_q - m_q;
      default: sum_s = a_q;
    endcase
    if (start) begin
      a_d   = {(DW + 1){1'b0}};
      m_d   = {m[DW-1], m};
      q_d   = q;
      q1_d  = 1'b0;
      cnt_d = CNT_W'(DW);
      run_d = 1'b1;
    end else if (run_q) begin
      a_d    = {sum_s[DW], sum_s[DW:1]};
      q_d    = {sum_s[0], q_q[DW-1:1]};
      q1_d   = q_q[0];
      cnt_d  = cnt_q - CNT_W'(1);
      run_d  = (cnt_q != CNT_W'(1));
      done_d = (cnt_q == CNT_W'(1));
    end else begin
      run_d = 1'b0;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= {(DW + 1){1'b0}};
      m_q    <= {(DW + 1){1'b0}};
      q_q    <= {DW{1'b0}};
      q1_q   <= 1'b0;
      run_q  <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      m_q    <= m_d;
      q_q    <= q_d;
      q1_q   <= q1_d;
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign product = {a_q[DW-1:0], q_q};
  assign done    = done_q;

endmodule

// File: rtl/multi_channel_mac.sv
// Multi-channel multiply-accumulate engine: Booth multiply, guarded accumulate with
// optional saturation, and a held dump port per channel on request.
module multi_channel_mac
  import mac_pkg::*;
#(
  parameter int  DATA_WIDTH = 16,
  parameter int  GUARD_BITS = 8,
  parameter int  NUM_CH     = 4,
  parameter int  SATURATE   = 1,
  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, GUARD_BITS),
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_a,
  input  logic signed [DATA_WIDTH-1:0] in_b,
  input  logic [CH_W-1:0]              in_ch,
  input  logic                         in_clr,
  input  logic                         in_last,
  input  logic                         clr_all,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_ovf,
  output logic                         busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [MAX_ACC_W-1:0] SAT_MAX_FULL = sat_max(ACC_WIDTH);
  localparam logic [MAX_ACC_W-1:0] SAT_MIN_FULL = sat_min(ACC_WIDTH);
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = SAT_MAX_FULL[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = SAT_MIN_FULL[ACC_WIDTH-1:0];

  state_t                         state_q;
  logic [CH_W-1:0]                ch_q;
  logic                           clr_q;
  logic                           last_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [ACC_WIDTH-1:0]           acc_q [NUM_CH];
  logic [NUM_CH-1:0]              ovf_q;
  logic                           out_valid_q;
  logic [ACC_WIDTH-1:0]           out_data_q;
  logic [CH_W-1:0]                out_ch_q;
  logic                           out_ovf_q;

  logic                           start_s;
  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic                           mul_done_s;
  logic                           ch_hit_s;
  logic [ACC_WIDTH-1:0]           sel_acc_s;
  logic                           sel_ovf_s;
  logic [ACC_WIDTH-1:0]           base_s;
  logic signed [ACC_WIDTH-1:0]    p_ext_s;
  logic [ACC_WIDTH:0]             sum_s;
  logic                           ovf_now_s;
  logic [ACC_WIDTH-1:0]           res_s;
  logic                           new_ovf_s;

  assign start_s = in_valid && (state_q == IDLE);

  booth_seq_core #(
    .DW(DATA_WIDTH)
  ) u_booth (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s),
    .m       (in_a),
    .q       (in_b),
    .product (prod_s),
    .done    (mul_done_s)
  );

  // Channel select (out-of-range channels select nothing) and the guarded add/saturate.
  always_comb begin
    ch_hit_s  = 1'b0;
    sel_acc_s = {ACC_WIDTH{1'b0}};
    sel_ovf_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit_s  = ch_hit_s | (ch_q == CH_W'(i));
      sel_acc_s = sel_acc_s | ({ACC_WIDTH{ch_q == CH_W'(i)}} & acc_q[i]);
      sel_ovf_s = sel_ovf_s | ((ch_q == CH_W'(i)) & ovf_q[i]);
    end
    base_s    = clr_q ? {ACC_WIDTH{1'b0}} : sel_acc_s;
    p_ext_s   = ACC_WIDTH'(prod_s);
    sum_s     = {base_s[ACC_WIDTH-1], base_s} + {p_ext_s[ACC_WIDTH-1], p_ext_s};
    ovf_now_s = sum_s[ACC_WIDTH] ^ sum_s[ACC_WIDTH-1];
    if (ovf_now_s && (SATURATE != 0)) begin
      res_s = sum_s[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      res_s = sum_s[ACC_WIDTH-1:0];
    end
    new_ovf_s = (~clr_q & sel_ovf_s) | ovf_now_s;
  end

  // Control FSM, channel register file and output register; clr_all overrides any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= {CH_W{1'b0}};
      clr_q       <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      ovf_q       <= {NUM_CH{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {ACC_WIDTH{1'b0}};
      out_ch_q    <= {CH_W{1'b0}};
      out_ovf_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= {ACC_WIDTH{1'b0}};
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            ch_q    <= in_ch;
            clr_q   <= in_clr;
            last_q  <= in_last;
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= MULT;
          end
        end
        MULT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_q <= ACC;
          end
        end
        ACC: begin
          if (mul_done_s) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (ch_q == CH_W'(i)) begin
                acc_q[i] <= res_s;
                ovf_q[i] <= new_ovf_s;
              end
            end
            if (last_q) begin
              out_valid_q <= 1'b1;
              out_ch_q    <= ch_q;
              out_data_q  <= (ch_hit_s && !clr_all) ? res_s : {ACC_WIDTH{1'b0}};
              out_ovf_q   <= ch_hit_s & new_ovf_s & ~clr_all;
              state_q     <= OUT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
              if (ch_q == CH_W'(i)) begin
                acc_q[i] <= {ACC_WIDTH{1'b0}};
                ovf_q[i] <= 1'b0;
              end
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (clr_all) begin
        ovf_q <= {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
          acc_q[i] <= {ACC_WIDTH{1'b0}};
        end
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_multi_channel_mac.sv
// Bench for multi_channel_mac: a cycle-level arithmetic model checks the default
// instance every cycle; two narrow instances exercise saturate and wrap overflow.
module tb_multi_channel_mac;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_a = 16'sd0;
  logic signed [15:0] in_b = 16'sd0;
  logic [1:0]         in_ch = 2'd0;
  logic               in_clr = 1'b0;
  logic               in_last = 1'b0;
  logic               clr_all = 1'b0;
  logic               out_ready = 1'b0;
  logic               in_ready, out_valid, out_ovf, busy;
  logic [39:0]        out_data;
  logic [1:0]         out_ch;

  logic               s_valid = 1'b0;
  logic signed [3:0]  s_a = 4'sd0;
  logic signed [3:0]  s_b = 4'sd0;
  logic [1:0]         s_ch = 2'd0;
  logic               s_clr = 1'b0;
  logic               s_last = 1'b0;
  logic               s_clr_all = 1'b0;
  logic               s_out_ready = 1'b0;
  logic               sat_in_ready, sat_out_valid, sat_out_ovf, sat_busy;
  logic [7:0]         sat_out_data;
  logic [1:0]         sat_out_ch;
  logic               wr_in_ready, wr_out_valid, wr_out_ovf, wr_busy;
  logic [7:0]         wr_out_data;
  logic [1:0]         wr_out_ch;

  int n_chk = 0;
  int n_err = 0;
  int lat;

  always #5 clk = ~clk;

  multi_channel_mac #(.DATA_WIDTH(16), .GUARD_BITS(8), .NUM_CH(4), .SATURATE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_ch(in_ch), .in_clr(in_clr), .in_last(in_last), .clr_all(clr_all),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_ovf(out_ovf), .busy(busy));

  multi_channel_mac #(.DATA_WIDTH(4), .GUARD_BITS(0), .NUM_CH(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(sat_in_ready), .in_a(s_a),
    .in_b(s_b), .in_ch(s_ch), .in_clr(s_clr), .in_last(s_last), .clr_all(s_clr_all),
    .out_valid(sat_out_valid), .out_ready(s_out_ready), .out_data(sat_out_data),
    .out_ch(sat_out_ch), .out_ovf(sat_out_ovf), .busy(sat_busy));

  multi_channel_mac #(.DATA_WIDTH(4), .GUARD_BITS(0), .NUM_CH(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(wr_in_ready), .in_a(s_a),
    .in_b(s_b), .in_ch(s_ch), .in_clr(s_clr), .in_last(s_last), .clr_all(s_clr_all),
    .out_valid(wr_out_valid), .out_ready(s_out_ready), .out_data(wr_out_data),
    .out_ch(wr_out_ch), .out_ovf(wr_out_ovf), .busy(wr_busy));

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of the default instance: 0 idle, 1 multiplying/accumulating, 2 holding a dump.
  localparam longint AMAX = (longint'(1) <<< 39) - 64'sd1;
  localparam longint AMIN = -(longint'(1) <<< 39);
  int     m_state, m_cnt, m_ch, m_out_ch;
  longint m_acc[4];
  bit     m_ovf[4];
  longint m_prod, m_out_data, m_sum;
  bit     m_clr, m_last, m_out_ovf, m_o;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0;
      m_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        m_acc[i] = 0;
        m_ovf[i] = 1'b0;
      end
    end else begin
      if (m_state == 0) begin
        if (in_valid) begin
          m_prod  = longint'(in_a) * longint'(in_b);
          m_ch    = int'(in_ch);
          m_clr   = in_clr;
          m_last  = in_last;
          m_cnt   = 17;
          m_state = 1;
        end
      end else if (m_state == 1) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_sum = (m_clr ? 64'sd0 : m_acc[m_ch]) + m_prod;
          m_o   = (m_sum > AMAX) || (m_sum < AMIN);
          if (m_sum > AMAX) m_sum = AMAX;
          if (m_sum < AMIN) m_sum = AMIN;
          m_o = m_o | (!m_clr && m_ovf[m_ch]);
          m_acc[m_ch] = m_sum;
          m_ovf[m_ch] = m_o;
          if (clr_all) begin
            m_sum = 0;
            m_o   = 1'b0;
          end
          if (m_last) begin
            m_out_data = m_sum;
            m_out_ovf  = m_o;
            m_out_ch   = m_ch;
            m_state    = 2;
          end else begin
            m_state = 0;
          end
        end
      end else if (out_ready) begin
        m_acc[m_ch] = 0;
        m_ovf[m_ch] = 1'b0;
        m_state = 0;
      end
      if (clr_all) begin
        for (int i = 0; i < 4; i++) begin
          m_acc[i] = 0;
          m_ovf[i] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of the default instance against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, m_state == 0);
      check("busy", busy, m_state != 0);
      check("out_valid", out_valid, m_state == 2);
      if (m_state == 2) begin
        check("out_data", longint'($signed(out_data)), m_out_data);
        check("out_ch", out_ch, m_out_ch);
        check("out_ovf", out_ovf, m_out_ovf);
      end
    end
  end

  task automatic send(input int a, input int b, input int ch, input bit clr, input bit last);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_a = 16'(a);
    in_b = 16'(b);
    in_ch = 2'(ch);
    in_clr = clr;
    in_last = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_clr = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_dump(input string name, input longint exp_d, input int exp_ch,
                           input bit exp_ovf, input int hold, output int lat_o);
    lat_o = 0;
    while (!out_valid && lat_o < 200) begin
      @(negedge clk);
      lat_o++;
    end
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, longint'($signed(out_data)), exp_d);
    check({name, "_ch"}, out_ch, exp_ch);
    check({name, "_ovf"}, out_ovf, exp_ovf);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_data"}, longint'($signed(out_data)), exp_d);
      check({name, "_hold_ch"}, out_ch, exp_ch);
      check({name, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic send4(input int a, input int b, input int ch, input bit clr, input bit last);
    int n;
    n = 0;
    @(negedge clk);
    while (!sat_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sat_in_ready) check("send4_timeout", sat_in_ready, 1);
    s_valid = 1'b1;
    s_a = 4'(a);
    s_b = 4'(b);
    s_ch = 2'(ch);
    s_clr = clr;
    s_last = last;
    @(negedge clk);
    s_valid = 1'b0;
    s_clr = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic dump4(input string name, input longint sat_d, input longint wr_d, input bit exp_ovf);
    int n;
    n = 0;
    while (!sat_out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_sat_valid"}, sat_out_valid, 1);
    check({name, "_wrap_valid"}, wr_out_valid, 1);
    check({name, "_sat_data"}, longint'($signed(sat_out_data)), sat_d);
    check({name, "_wrap_data"}, longint'($signed(wr_out_data)), wr_d);
    check({name, "_sat_ch"}, sat_out_ch, 2);
    check({name, "_wrap_ch"}, wr_out_ch, 2);
    check({name, "_sat_ovf"}, sat_out_ovf, exp_ovf);
    check({name, "_wrap_ovf"}, wr_out_ovf, exp_ovf);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_sat_busy", sat_busy, 0);
    check("rst_wrap_busy", wr_busy, 0);
    #2 rst_n = 1'b1;

    // Asynchronous reset in the middle of a multiply wipes ch0.
    send(5, 5, 0, 1'b1, 1'b0);
    send(7, 7, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", longint'(out_data), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1);
    send(0, 0, 0, 1'b0, 1'b1);
    wait_dump("rst_dump", 0, 0, 1'b0, 0, lat);

    send(3, 4, 0, 1'b1, 1'b0);
    send(-5, 7, 0, 1'b0, 1'b1);
    wait_dump("basic", -23, 0, 1'b0, 0, lat);
    check("basic_latency", lat, 17);

    send(-32768, -32768, 1, 1'b1, 1'b1);
    wait_dump("corner", 64'h4000_0000, 1, 1'b0, 0, lat);

    send(100, -3, 2, 1'b1, 1'b1);
    wait_dump("bp", -300, 2, 1'b0, 5, lat);
    send(1, 1, 2, 1'b0, 1'b1);
    wait_dump("bp_next", 1, 2, 1'b0, 0, lat);

    // clr_all in the middle of a ch3 multiply leaves only the in-flight product.
    send(2, 2, 0, 1'b1, 1'b0);
    send(2, 2, 3, 1'b1, 1'b0);
    send(2, 2, 3, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
    wait_dump("iso_ch3", 4, 3, 1'b0, 0, lat);
    send(0, 0, 0, 1'b0, 1'b1);
    wait_dump("iso_ch0", 0, 0, 1'b0, 0, lat);

    send4(-8, -8, 2, 1'b1, 1'b0);
    send4(-8, -8, 2, 1'b0, 1'b1);
    dump4("ovf", 127, -128, 1'b1);
    send4(1, 1, 2, 1'b0, 1'b1);
    dump4("ovf_next", 1, 1, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_channel_mac.md
# multi_channel_mac

Parametrised multiply-accumulate engine with `NUM_CH` independent accumulator channels. It uses a sequential radix-2 Booth multiplier, adds guard-bit sign extension and optional saturation, and uses valid/ready handshakes on both input and output. It sits between the operand stream source and the result consumer. It is the channelised, width-generic successor to the single-channel booth/accumulator pair.

## Interface
- `DATA_WIDTH`, 16: signed operand width; product is `2*DATA_WIDTH`.
- `GUARD_BITS`, 8: accumulator headroom; `ACC_WIDTH = 2*DATA_WIDTH + GUARD_BITS`.
- `NUM_CH`, 4: number of accumulator channels (≥1); `CH_W = max(1, $clog2(NUM_CH))`.
- `SATURATE`, 1: 1 = clamp on overflow, 0 = two's-complement wrap.
- One clock; reset is asynchronous and active-low.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: engine can accept a beat.
- `in_a` in `DATA_WIDTH`: signed multiplicand.
- `in_b` in `DATA_WIDTH`: signed multiplier.
- `in_ch` in `CH_W`: target channel.
- `in_clr` in 1: load the product into the channel instead of adding it.
- `in_last` in 1: after the update, dump the channel to the output and zero it.
- `clr_all` in 1: synchronous clear of all channels and flags.
- `out_valid` out 1: dump result valid.
- `out_ready` in 1: consumer accepts the dump.
- `out_data` out `ACC_WIDTH`: signed dumped accumulator value.
- `out_ch` out `CH_W`: channel of the dump.
- `out_ovf` out 1: sticky overflow flag of the dumped channel.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, MULT, ACC, OUT.
- IDLE: `in_ready=1`. When `in_valid & in_ready`, capture `a`, `b`, `ch`, `clr`, `last` and go to MULT.
- MULT: exactly `DATA_WIDTH` Booth steps, one per cycle, then go to ACC.
  - Partial register A is `DATA_WIDTH+1` bits, so `(-2^(DW-1))²` is exact.
- ACC: one cycle.
  - Sign-extend the product to `ACC_WIDTH`.
  - `sum = clr ? p : acc[ch] + p`, computed at `ACC_WIDTH+1` bits.
  - On overflow: if `SATURATE`, clamp to `2^(ACC_WIDTH-1)-1` or `-2^(ACC_WIDTH-1)`, else wrap. In both modes set `ovf[ch]`.
  - `clr=1` resets `ovf[ch]` before evaluating.
  - If `last`, latch `out_data`, `out_ch`, `out_ovf` from the updated value and go to OUT. Otherwise go to IDLE.
- OUT: hold `out_valid` and the outputs stable until `out_ready`. On the handshake, zero `acc[ch]` and `ovf[ch]`, then go to IDLE.
- Out-of-range `in_ch` (≥ `NUM_CH`): the beat is accepted and multiplied, the channel write is dropped, and a `last` dump reports data 0 with `ovf` 0.
- `clr_all`: zeroes every acc and ovf on that edge and does not abort the FSM.
  - If it coincides with the ACC edge, `clr_all` wins: the write is lost, and a `last` dump reports 0.
  - If it coincides with the OUT handshake, the result is the same (all zero).

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_data=0`, `out_ch=0`, `out_ovf=0`, `busy=0`; all acc and ovf = 0; state IDLE.
- `rst_n` low mid-operation aborts immediately and discards the beat.
- Input handshake at edge E0.
  - MULT spans edges E1..E`DW`.
  - ACC writes at E`DW+1`.
  - `out_valid` rises after E`DW+1`.
- Throughput without a dump: one beat per `DATA_WIDTH+2` cycles, with `in_ready` low for `DATA_WIDTH+1` cycles after acceptance.
- With a dump, `in_ready` stays low until the cycle after the output handshake. There is no input/output overlap.
- `out_valid` never drops without `out_ready`.

## Structure
- Package `mac_pkg`:
  - `state_t` enum (IDLE, MULT, ACC, OUT).
  - `acc_width(dw, gb)` function.
  - Saturation max/min constant functions.
- Sub-module `booth_seq_core`:
  - Ports `clk`, `rst_n`, `start`, `m`, `q`, `product`, `done`.
  - Runs the `DATA_WIDTH`-step sequence.
  - Pulses `done` for one cycle with the product held until the next `start`.
- Top level holds the FSM, the channel register file (flops, `NUM_CH × ACC_WIDTH`), the ovf vector, and the output register.

## Test plan
- **Reset:** assert `rst_n` low mid-MULT → all outputs at reset values, `in_ready=1` next cycle; a following dump of ch0 returns 0.
- **Basic accumulate:** defaults; ch0: 3×4 with `clr`, then -5×7 with `last` → `out_data=-23`, `out_ch=0`, `out_ovf=0`; `out_valid` rises 17 cycles after the second handshake.
- **Corner product:** -32768 × -32768 on ch1 with `clr` and `last` → `out_data=0x40000000`.
- **Overflow:** `DATA_WIDTH=4`, `GUARD_BITS=0`; -8×-8 twice on ch2 with `last` on the second.
  - `SATURATE=1` → 127, `ovf=1`.
  - `SATURATE=0` → -128, `ovf=1`.
  - Next dump of ch2 with `ovf=0`.
- **Backpressure:** hold `out_ready` low 5 cycles → `out_data`/`out_ch` stable, `in_ready=0`; after the handshake, a 1×1 `last` on the same channel returns 1.
- **Isolation and clear:**
  - Accumulate 2×2 on ch0 and ch3.
  - Pulse `clr_all` during a ch3 MULT → the ch3 dump equals only the in-flight product.
  - A ch0 dump returns 0.
